// File: rtl/pslip_grant_arb_if.sv
// Handshake bundle between the pSLIP priority selector, the grant stage and
// the input-side accept arbiter.
interface pslip_grant_arb_if #(
  parameter int N = 16,
  parameter int P = 32,
  parameter int C = $clog2(P),
  parameter int W = $clog2(N)
) ();
  logic         req_valid;
  logic [N-1:0] req;
  logic [C-1:0] prio;
  logic         busy;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic [C-1:0] gnt_prio;
  logic         gnt_valid;
  logic         acc_valid;
  logic         acc;
  logic         timeout;

  modport master (
    output req_valid, req, prio, acc_valid, acc,
    input  busy, gnt, gnt_idx, gnt_prio, gnt_valid, timeout
  );

  modport slave (
    input  req_valid, req, prio, acc_valid, acc,
    output busy, gnt, gnt_idx, gnt_prio, gnt_valid, timeout
  );
endinterface

// File: rtl/pslip_grant_arb.sv
// pSLIP output-port grant stage: round-robin grant per priority level, pointer
// advanced only on an accepted grant, unanswered grants dropped after TIMEOUT.
module pslip_grant_arb #(
  parameter int N       = 16,
  parameter int P       = 32,
  parameter int C       = $clog2(P),
  parameter int W       = $clog2(N),
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  pslip_grant_arb_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARB, WAIT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] req_q, req_d;
  logic [C-1:0] prio_q, prio_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [W-1:0] gnt_idx_q, gnt_idx_d;
  logic [C-1:0] gnt_prio_q, gnt_prio_d;
  logic         gnt_valid_q, gnt_valid_d;
  logic         timeout_q, timeout_d;
  logic [W-1:0] ptr_q [P];
  logic         ptr_we;
  logic [W-1:0] winner;

  // Circular search: first set bit at or after base, wrapping N-1 -> 0.
  function automatic logic [W-1:0] first_from(input logic [N-1:0] r,
                                              input logic [W-1:0] base);
    logic [W-1:0] idx;
    logic         found;
    first_from = base;
    found      = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = base + W'(k);
      if (!found && r[idx]) begin
        first_from = idx;
        found      = 1'b1;
      end
    end
  endfunction

  assign winner = first_from(req_q, ptr_q[prio_q]);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    prio_d      = prio_q;
    timer_d     = timer_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_prio_d  = gnt_prio_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    ptr_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && (|bus.req)) begin
          req_d   = bus.req;
          prio_d  = bus.prio;
          state_d = ARB;
        end
      end
      ARB: begin
        gnt_d         = '0;
        gnt_d[winner] = 1'b1;
        gnt_idx_d     = winner;
        gnt_prio_d    = prio_q;
        gnt_valid_d   = 1'b1;
        timer_d       = '0;
        state_d       = WAIT;
      end
      WAIT: begin
        // A response in the expiry cycle takes precedence over the timeout.
        if (bus.acc_valid || (timer_q == TW'(TIMEOUT - 1))) begin
          ptr_we      = bus.acc_valid && bus.acc;
          timeout_d   = !bus.acc_valid;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_prio_d  = '0;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      prio_q      <= '0;
      timer_q     <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_prio_q  <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      for (int i = 0; i < P; i++) ptr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      prio_q      <= prio_d;
      timer_q     <= timer_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_prio_q  <= gnt_prio_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      if (ptr_we) ptr_q[gnt_prio_q] <= gnt_idx_q + W'(1);
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_prio  = gnt_prio_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule
